scrypt_romix_ctrl: RTL and testbench
====================================

// Module: scrypt_romix_ctrl
// PURPOSE
//  Sequencer for scrypt ROMix around the 16-cycle salsa block (two chained salsa20/8 on 512-bit halves).
//  Owns the N x 1024-bit scratchpad V and the 1024-bit working state X.
//  Write phase: N iterations of V[i]=X; X=BlockMix(X).
//  Read phase: N iterations of j=X[16] mod N; X=BlockMix(X^V[j]).
//  Sits between the PBKDF2/SHA front end (data_in/data_out) and the salsa block (salsa_* ports).
// PARAMETERS
//  ADDRBITS   10  log2(N), scratchpad depth N=2**ADDRBITS; legal 1..10
//  SALSA_LAT  16  salsa input-to-output latency in clocks
// PORTS
//  clk          in   1     clock, all logic on posedge
//  reset        in   1     synchronous, active-high
//  start        in   1     request; accepted only in IDLE
//  data_in      in   1024  initial X; word k at [32k+31:32k]
//  busy         out  1     high from accept until done
//  done         out  1     one-cycle pulse, final X valid on data_out
//  data_out     out  1024  X register, held until next accept
//  salsa_B      out  512   X[511:0] (X0), combinational from X reg
//  salsa_Bx     out  512   X[1023:512] (X1), combinational from X reg
//  salsa_Bo     in   512   new X1 from salsa
//  salsa_X0out  in   512   new X0 from salsa
//  salsa_Xaddr  in   10    low bits of new X1 word 0 (next j)
// BEHAVIOUR
//  Interface: one clock (clk); reset synchronous, active-high.
//  Reset: state=IDLE, busy=0, done=0, X=0 (so data_out=0), i=0, j=0, wcnt=0.
//   Scratchpad contents are not reset.
//  States: IDLE, WR, RD_FETCH, RD_MIX, RD_WAIT, DONE.
//  Salsa has no valid signal: the controller holds X stable and captures exactly SALSA_LAT cycles later.
//  IDLE: start=1 -> X<=data_in, i<=0, wcnt<=0, busy<=1, ->WR. start=0 -> stay.
//  WR, cycle wcnt=0: V[i]<=X.
//   wcnt counts 0..SALSA_LAT.
//   At wcnt=SALSA_LAT: X<={salsa_Bo,salsa_X0out}, j<=salsa_Xaddr[ADDRBITS-1:0], wcnt<=0.
//   If i=N-1: i<=0, ->RD_FETCH. Else i<=i+1, stay in WR.
//   Iteration = SALSA_LAT+1 cycles.
//  RD_FETCH: scratchpad read at address j; registered dout, 1 cycle.
//  RD_MIX: X<=X^dout, wcnt<=0, ->RD_WAIT.
//  RD_WAIT: wcnt counts 0..SALSA_LAT.
//   At wcnt=SALSA_LAT: capture X and j as in WR.
//   If i=N-1 -> DONE. Else i<=i+1, ->RD_FETCH.
//   Iteration = SALSA_LAT+3 cycles.
//  DONE: done=1 for one cycle, busy<=0, ->IDLE.
//   start seen in DONE is ignored; it is accepted in IDLE on a later cycle.
//  Latency, accept edge to done=1 cycle: N*(SALSA_LAT+1) + N*(SALSA_LAT+3) cycles.
//   Default N=1024, SALSA_LAT=16: 36864.
//  start while busy=1: ignored, no effect on state or data.
//  j wraps: upper Xaddr bits above ADDRBITS are dropped (j = X[512+:32] mod N).
//  Counters: i is ADDRBITS wide and compared to N-1, never wraps mid-phase.
//   wcnt width is ceil(log2(SALSA_LAT+1)).
//  XOR and BlockMix are bitwise on full 1024 bits.
//   Word 16 (X[543:512]) drives j.
//  Reset in any state, including mid-phase: next cycle IDLE, busy=0, done=0.
//   No scratchpad write occurs in the reset cycle.
//  Scratchpad: single port, 1 write or 1 read per cycle, never both.
//   Inferred block RAM with registered read.
// TESTING
//  1 Assert reset 2 cycles -> busy=0, done=0, data_out=0. start with reset=1 -> no accept.
//  2 Real salsa, data_in = scrypt vector ("password"/"NaCl"-derived X), N=1024
//    -> done exactly 36864 cycles after accept; data_out == C ROMix model.
//  3 ADDRBITS=2, behavioural salsa model -> V writes at addr 0,1,2,3 at cycles 0,17,34,51 after accept.
//    Read addresses equal model j sequence; done at cycle 144.
//  4 start pulsed every cycle while busy -> single run, result identical to test 2.
//    start held through DONE -> new accept on the IDLE cycle after done.
//  5 reset at cycle 20000 (read phase) -> IDLE next cycle.
//    Restart with data_in=0 -> output matches model for data_in=0.
//  6 ADDRBITS=4, salsa stub with Xaddr=10'h3F5 -> RD_FETCH address = 4'h5.

Source files
------------

// File: rtl/scrypt_romix_if.sv
// Bus between the scrypt ROMix sequencer, the PBKDF2/SHA front end and the
// salsa block.
//   start, data_in           front end -> sequencer (request, initial X)
//   busy, done, data_out     sequencer -> front end (status, final X)
//   salsa_B, salsa_Bx        sequencer -> salsa (X0 and X1 halves of X)
//   salsa_Bo, salsa_X0out    salsa -> sequencer (new X1, new X0)
//   salsa_Xaddr              salsa -> sequencer (low bits of new X1 word 0)
// The sequencer connects through the slave modport; whatever drives it
// (front end plus salsa block, or a bench) uses the master modport.
interface scrypt_romix_if;
    logic          start;
    logic          busy;
    logic          done;
    logic [1023:0] data_in;
    logic [1023:0] data_out;
    logic [511:0]  salsa_B;
    logic [511:0]  salsa_Bx;
    logic [511:0]  salsa_Bo;
    logic [511:0]  salsa_X0out;
    logic [9:0]    salsa_Xaddr;

    modport master (
        output start, data_in, salsa_Bo, salsa_X0out, salsa_Xaddr,
        input  busy, done, data_out, salsa_B, salsa_Bx
    );

    modport slave (
        input  start, data_in, salsa_Bo, salsa_X0out, salsa_Xaddr,
        output busy, done, data_out, salsa_B, salsa_Bx
    );
endinterface

// File: rtl/scrypt_romix_ctrl.sv
// scrypt ROMix sequencer. Owns the N x 1024-bit scratchpad V and the
// 1024-bit working state X, and drives a fixed-latency salsa block that has
// no valid signal.
//   Write phase: N times { V[i] = X; X = BlockMix(X) }
//   Read phase : N times { j = X[16] mod N; X = BlockMix(X ^ V[j]) }
// Ports:
//   clk    clock, everything on the rising edge
//   reset  synchronous, active-high
//   bus    scrypt_romix_if.slave (front-end handshake + salsa datapath)
// Parameters:
//   ADDRBITS   log2 of scratchpad depth N (1..10)
//   SALSA_LAT  salsa input-to-output latency in clocks
module scrypt_romix_ctrl #(
    parameter int ADDRBITS  = 10,
    parameter int SALSA_LAT = 16
) (
    input  logic          clk,
    input  logic          reset,
    scrypt_romix_if.slave bus
);

    localparam int N   = 1 << ADDRBITS;
    localparam int WCW = $clog2(SALSA_LAT + 1);
    localparam logic [WCW-1:0]      WLAST = WCW'(SALSA_LAT);
    localparam logic [ADDRBITS-1:0] ILAST = {ADDRBITS{1'b1}};

    typedef enum logic [2:0] {
        IDLE, WR, RD_FETCH, RD_MIX, RD_WAIT, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1023:0]        x_q, x_d;
    logic [1023:0]        dout_q;
    logic [ADDRBITS-1:0]  i_q, i_d, j_q, j_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic                 busy_q, busy_d;
    logic                 wr_en, rd_en;
    logic [ADDRBITS-1:0]  ram_addr;
    logic                 last_iter, wdone;
    logic                 unused_xaddr;

    logic [1023:0] mem [N];

    // Only the low ADDRBITS of the salsa word-16 address are meaningful.
    assign unused_xaddr = ^bus.salsa_Xaddr;

    assign last_iter = (i_q == ILAST);
    assign wdone     = (wcnt_q == WLAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            i_q     <= i_d;
            j_q     <= j_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic. X is held stable for the whole salsa window and the
    // result is captured exactly SALSA_LAT cycles after X last changed.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        i_d     = i_q;
        j_d     = j_q;
        wcnt_d  = wcnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = bus.data_in;
                    i_d     = '0;
                    wcnt_d  = '0;
                    busy_d  = 1'b1;
                    state_d = WR;
                end
            end
            WR: begin
                if (wdone) begin
                    x_d    = {bus.salsa_Bo, bus.salsa_X0out};
                    j_d    = bus.salsa_Xaddr[ADDRBITS-1:0];
                    wcnt_d = '0;
                    if (last_iter) begin
                        i_d     = '0;
                        state_d = RD_FETCH;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            RD_FETCH: state_d = RD_MIX;
            RD_MIX: begin
                x_d     = x_q ^ dout_q;
                wcnt_d  = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (wdone) begin
                    x_d    = {bus.salsa_Bo, bus.salsa_X0out};
                    j_d    = bus.salsa_Xaddr[ADDRBITS-1:0];
                    wcnt_d = '0;
                    if (last_iter) begin
                        state_d = DONE;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = RD_FETCH;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-port scratchpad: write on the first cycle of each write-phase
    // iteration, read in RD_FETCH; the two never coincide. The write is
    // suppressed during a reset cycle so an abort cannot corrupt V.
    assign wr_en    = (state_q == WR) && (wcnt_q == '0) && !reset;
    assign rd_en    = (state_q == RD_FETCH);
    assign ram_addr = rd_en ? j_q : i_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ram_addr] <= x_q;
        end
        if (rd_en) begin
            dout_q <= mem[ram_addr];
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = (state_q == DONE);
    assign bus.data_out = x_q;
    assign bus.salsa_B  = x_q[511:0];
    assign bus.salsa_Bx = x_q[1023:512];

endmodule

// File: tb/tb_scrypt_romix_ctrl.sv
// Bench for scrypt_romix_ctrl with N=8 and a behavioural 16-cycle salsa
// stand-in. Expected final X and read addresses come from a software ROMix
// model using the same stand-in mixing function.
module tb_scrypt_romix_ctrl;

    localparam int AB     = 3;
    localparam int N      = 1 << AB;
    localparam int LAT    = 16;
    localparam int RUNLEN = N * (LAT + 1) + N * (LAT + 3);

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scrypt_romix_if bus ();

    scrypt_romix_ctrl #(.ADDRBITS(AB), .SALSA_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in BlockMix: any bijective-ish 1024-bit scramble works here.
    function automatic logic [1023:0] mix(input logic [1023:0] x);
        logic [511:0] a, b;
        a = x[511:0] + {x[1022:512], x[1023]};
        b = x[1023:512] ^ {a[500:0], a[511:501]} ^ 512'h9E3779B97F4A7C15;
        return {b, a};
    endfunction

    // Salsa stand-in: pure pipeline, output reflects input LAT cycles ago.
    logic [1023:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mix({bus.salsa_Bx, bus.salsa_B});
        for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    end
    assign bus.salsa_Bo    = pipe[LAT-1][1023:512];
    assign bus.salsa_X0out = pipe[LAT-1][511:0];
    assign bus.salsa_Xaddr = pipe[LAT-1][521:512];

    logic [1023:0] exp_q [$];
    int            j_q   [$];

    task automatic model(input logic [1023:0] x_in);
        logic [1023:0] v [N];
        logic [1023:0] x;
        int j;
        x = x_in;
        for (int i = 0; i < N; i++) begin
            v[i] = x;
            x = mix(x);
        end
        for (int i = 0; i < N; i++) begin
            j = int'(x[512 +: AB]);
            j_q.push_back(j);
            x = mix(x ^ v[j]);
        end
        exp_q.push_back(x);
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h (differing bits %0d)",
                   tag, obs[127:0], exp[127:0], $countones(obs ^ exp));
        end
    endtask

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: scratchpad write address/timing and read address sequence.
    int acc_cyc = 0;
    initial begin
        logic busy_prev;
        int   wr_idx;
        busy_prev = 1'b0;
        wr_idx    = 0;
        forever begin
            @(negedge clk);
            if (bus.busy && !busy_prev) begin
                acc_cyc = cyc;
                wr_idx  = 0;
            end
            busy_prev = bus.busy;
            if (dut.wr_en) begin
                chk("wr_addr", 1024'(dut.ram_addr), 1024'(wr_idx));
                chk("wr_cycle", 1024'(cyc - acc_cyc), 1024'(wr_idx * (LAT + 1)));
                wr_idx++;
            end
            if (dut.rd_en) begin
                if (j_q.size() == 0) chk("rd_addr_unexpected", 1024'(1), 1024'(0));
                else chk("rd_addr", 1024'(dut.ram_addr), 1024'(j_q.pop_front()));
            end
        end
    end

    task automatic launch(input logic [1023:0] d);
        bus.data_in = d;
        bus.start   = 1'b1;
        model(d);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_accept", 1024'(bus.busy), 1024'(1));
    endtask

    // Wait for done (bounded), then compare latency and popped result.
    task automatic wait_done(input string tag, input bit spam);
        int k;
        k = 0;
        while (!bus.done && k < RUNLEN + 100) begin
            @(negedge clk);
            if (spam) bus.data_in = rand1024();
            k++;
        end
        if (!bus.done) begin
            chk({tag, "_timeout"}, 1024'(0), 1024'(1));
        end else begin
            chk({tag, "_latency"}, 1024'(cyc - acc_cyc), 1024'(RUNLEN));
            if (exp_q.size() == 0) chk({tag, "_noexp"}, 1024'(1), 1024'(0));
            else chk({tag, "_result"}, bus.data_out, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [1023:0] dc;
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.data_in = rand1024();
        repeat (2) @(negedge clk);
        chk("rst_busy", 1024'(bus.busy), 1024'(0));
        chk("rst_done", 1024'(bus.done), 1024'(0));
        chk("rst_dout", bus.data_out, 1024'(0));
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("no_accept_in_reset", 1024'(bus.busy), 1024'(0));

        // Plain run
        launch(rand1024());
        wait_done("runA", 1'b0);
        @(negedge clk);
        chk("runA_done_pulse", 1024'(bus.done), 1024'(0));
        chk("runA_busy_clear", 1024'(bus.busy), 1024'(0));

        // start held high and data_in churning while busy, held through DONE
        bus.data_in = rand1024();
        bus.start   = 1'b1;
        model(bus.data_in);
        @(negedge clk);
        wait_done("runB", 1'b1);
        dc = rand1024();
        bus.data_in = dc;
        model(dc);
        @(negedge clk);
        chk("runB_idle_busy", 1024'(bus.busy), 1024'(0));
        chk("runB_idle_done", 1024'(bus.done), 1024'(0));
        @(negedge clk);
        chk("runC_reaccept", 1024'(bus.busy), 1024'(1));
        bus.start = 1'b0;
        wait_done("runC", 1'b0);
        @(negedge clk);

        // Abort in the read phase, then restart from X=0
        launch(rand1024());
        repeat (N * (LAT + 1) + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 1024'(bus.busy), 1024'(0));
        chk("abort_done", 1024'(bus.done), 1024'(0));
        chk("abort_dout", bus.data_out, 1024'(0));
        reset = 1'b0;
        exp_q.delete();
        j_q.delete();
        launch(1024'(0));
        wait_done("runZero", 1'b0);
        @(negedge clk);
        chk("runZero_busy_clear", 1024'(bus.busy), 1024'(0));
        chk("rd_queue_drained", 1024'(j_q.size()), 1024'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
